// File: rtl/player_bullet_pkg.sv
// Shared grid geometry, coordinate types and bullet state encodings.
// The invaders block imports the same definitions, so coordinates agree on both sides.
package player_bullet_pkg;

    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 15;
    localparam int COL_W     = 5;
    localparam int ROW_W     = 4;

    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;

    // Row 15 lies below the playfield and never holds an invader.
    localparam row_t OFFGRID_ROW = 4'd15;
    localparam col_t MAX_COL     = 5'(GRID_COLS - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FLYING   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    // A cannon column beyond the right edge fires from the last column.
    function automatic col_t clamp_col(input col_t col);
        return (col > MAX_COL) ? MAX_COL : col;
    endfunction

endpackage

// File: rtl/player_bullet_if.sv
// Bullet/hit link between the player cannon (master) and the invaders block (slave).
interface player_bullet_if
    import player_bullet_pkg::*;
;
    col_t bullet_x;
    row_t bullet_y;
    logic bullet_active;
    logic hit;

    modport master (
        output bullet_x,
        output bullet_y,
        output bullet_active,
        input  hit
    );

    modport slave (
        input  bullet_x,
        input  bullet_y,
        input  bullet_active,
        output hit
    );

endinterface

// File: rtl/player_bullet_step_timer.sv
// Modulo-STEP_DIV counter producing a one-cycle tick on terminal count.
// A synchronous clear restarts the period so the next tick is a full STEP_DIV away.
module player_bullet_step_timer #(
    parameter int STEP_DIV = 1250000
) (
    input  logic clk_25MHz,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] count;

    // Free-running period counter, restarted by clear and wrapping after the terminal count.
    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/player_bullet.sv
// Player bullet launcher: one bullet in flight, stepped up one row per tick,
// retired on a hit or past the top row, followed by a tick-counted cooldown.
module player_bullet
    import player_bullet_pkg::*;
#(
    parameter int STEP_DIV       = 1250000,
    parameter int COOLDOWN_STEPS = 4,
    parameter int LAUNCH_ROW     = 14
) (
    input  logic                 clk_25MHz,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 fire,
    input  logic [COL_W-1:0]     player_x,
    player_bullet_if.master      bus,
    output logic [7:0]           shots_fired,
    output logic [7:0]           hits_scored
);

    localparam int CDW = (COOLDOWN_STEPS > 1) ? $clog2(COOLDOWN_STEPS) : 1;
    localparam logic [CDW-1:0] CD_LAST = CDW'((COOLDOWN_STEPS > 0) ? (COOLDOWN_STEPS - 1) : 0);

    logic [1:0]     state;
    logic [CDW-1:0] cd_cnt;
    logic           fire_q;
    col_t           bullet_x_r;
    row_t           bullet_y_r;
    logic           bullet_active_r;

    logic tick;
    logic launch_req;
    logic launch;
    logic in_flight;
    logic retire_hit;
    logic retire_miss;
    logic abort;
    logic timer_clear;
    logic cd_done;

    // Launch and retire conditions; stop (start=0) overrides everything else.
    always_comb begin
        launch_req  = fire & ~fire_q;
        in_flight   = (state == ST_FLYING);
        launch      = (state == ST_IDLE) & start & launch_req;
        retire_hit  = in_flight & start & bus.hit;
        retire_miss = in_flight & start & ~bus.hit & tick & (bullet_y_r == '0);
        abort       = in_flight & ~start;
        timer_clear = launch | retire_hit | retire_miss | abort;
        cd_done     = (state == ST_COOLDOWN) &
                      ((COOLDOWN_STEPS == 0) | (tick & (cd_cnt == CD_LAST)));
    end

    player_bullet_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clk_25MHz (clk_25MHz),
        .reset     (reset),
        .clear     (timer_clear),
        .tick      (tick)
    );

    // Previous fire level, so a held button only launches on its rising edge.
    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            fire_q <= 1'b0;
        end else begin
            fire_q <= fire;
        end
    end

    // Bullet lifecycle state machine with its cooldown tick counter.
    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cd_cnt <= '0;
        end else if (!start) begin
            state  <= ST_IDLE;
            cd_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch_req) begin
                        state <= ST_FLYING;
                    end
                end
                ST_FLYING: begin
                    if (retire_hit || retire_miss) begin
                        state  <= ST_COOLDOWN;
                        cd_cnt <= '0;
                    end
                end
                ST_COOLDOWN: begin
                    if (cd_done) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        cd_cnt <= cd_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bullet position: column latched at launch, row parked off-grid whenever inactive.
    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            bullet_x_r      <= '0;
            bullet_y_r      <= OFFGRID_ROW;
            bullet_active_r <= 1'b0;
        end else if (launch) begin
            bullet_x_r      <= clamp_col(player_x);
            bullet_y_r      <= ROW_W'(LAUNCH_ROW);
            bullet_active_r <= 1'b1;
        end else if (retire_hit || retire_miss || abort) begin
            bullet_y_r      <= OFFGRID_ROW;
            bullet_active_r <= 1'b0;
        end else if (in_flight && tick) begin
            bullet_y_r      <= bullet_y_r - 1'b1;
        end
    end

    // Score counters: shots wrap naturally, hits stick at the maximum.
    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            shots_fired <= '0;
            hits_scored <= '0;
        end else begin
            if (launch) begin
                shots_fired <= shots_fired + 1'b1;
            end
            if (retire_hit && (hits_scored != 8'hFF)) begin
                hits_scored <= hits_scored + 1'b1;
            end
        end
    end

    assign bus.bullet_x      = bullet_x_r;
    assign bus.bullet_y      = bullet_y_r;
    assign bus.bullet_active = bullet_active_r;

endmodule

// File: tb/tb_player_bullet.sv
// Self-checking bench for player_bullet: a cycle model pushes the expected
// outputs when each cycle's stimulus is applied; they are popped and compared after the edge.
module tb_player_bullet;
    import player_bullet_pkg::*;

    localparam int STEP_DIV       = 4;
    localparam int COOLDOWN_STEPS = 2;
    localparam int LAUNCH_ROW     = 14;

    logic       clk_25MHz = 1'b0;
    logic       reset     = 1'b0;
    logic       start     = 1'b0;
    logic       fire      = 1'b0;
    logic [4:0] player_x  = 5'd0;
    logic [7:0] shots_fired;
    logic [7:0] hits_scored;

    player_bullet_if bus ();

    player_bullet #(
        .STEP_DIV       (STEP_DIV),
        .COOLDOWN_STEPS (COOLDOWN_STEPS),
        .LAUNCH_ROW     (LAUNCH_ROW)
    ) dut (
        .clk_25MHz   (clk_25MHz),
        .reset       (reset),
        .start       (start),
        .fire        (fire),
        .player_x    (player_x),
        .bus         (bus),
        .shots_fired (shots_fired),
        .hits_scored (hits_scored)
    );

    always #10 clk_25MHz = ~clk_25MHz;

    typedef struct packed {
        logic [4:0] x;
        logic [3:0] y;
        logic       act;
        logic [7:0] shots;
        logic [7:0] hits;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int         m_state;
    logic [4:0] m_x;
    int         m_y;
    logic       m_act;
    int         m_shots;
    int         m_hits;
    logic       m_fireq;
    int         m_div;
    int         m_cd;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_x     = 5'd0;
        m_y     = 15;
        m_act   = 1'b0;
        m_shots = 0;
        m_hits  = 0;
        m_fireq = 1'b0;
        m_div   = 0;
        m_cd    = 0;
    endtask

    task automatic model_retire();
        m_state = 2;
        m_act   = 1'b0;
        m_y     = 15;
        m_div   = 0;
        m_cd    = 0;
    endtask

    task automatic model_step(input logic s, input logic f, input logic [4:0] px, input logic h);
        logic edge_seen;
        logic tk;
        edge_seen = f && !m_fireq;
        tk        = (m_div == STEP_DIV - 1);
        m_fireq   = f;
        m_div     = tk ? 0 : m_div + 1;
        if (!s) begin
            if (m_state == 1) begin
                m_act = 1'b0;
                m_y   = 15;
            end
            m_state = 0;
        end else begin
            case (m_state)
                0: if (edge_seen) begin
                    m_state = 1;
                    m_x     = (px > 5'd19) ? 5'd19 : px;
                    m_y     = LAUNCH_ROW;
                    m_act   = 1'b1;
                    m_shots = (m_shots + 1) % 256;
                    m_div   = 0;
                end
                1: if (h) begin
                    model_retire();
                    if (m_hits < 255) m_hits++;
                end else if (tk && m_y == 0) begin
                    model_retire();
                end else if (tk) begin
                    m_y--;
                end
                default: if (tk) begin
                    if (m_cd + 1 >= COOLDOWN_STEPS) m_state = 0;
                    else m_cd++;
                end
            endcase
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic f, input logic [4:0] px, input logic h);
        exp_t e;
        start    = s;
        fire     = f;
        player_x = px;
        bus.hit  = h;
        model_step(s, f, px, h);
        e.x     = m_x;
        e.y     = 4'(m_y);
        e.act   = m_act;
        e.shots = 8'(m_shots);
        e.hits  = 8'(m_hits);
        sb.push_back(e);
        @(posedge clk_25MHz);
        #1;
        e = sb.pop_front();
        check_output("bullet_x", 32'(bus.bullet_x), 32'(e.x));
        check_output("bullet_y", 32'(bus.bullet_y), 32'(e.y));
        check_output("bullet_active", 32'(bus.bullet_active), 32'(e.act));
        check_output("shots_fired", 32'(shots_fired), 32'(e.shots));
        check_output("hits_scored", 32'(hits_scored), 32'(e.hits));
        check_output("offgrid_when_idle",
                     32'(bus.bullet_active ? 4'd15 : bus.bullet_y), 32'd15);
    endtask

    initial begin
        bus.hit = 1'b0;
        model_reset();

        // Reset values while reset is held low.
        repeat (3) @(posedge clk_25MHz);
        #1;
        check_output("rst_x", 32'(bus.bullet_x), 32'd0);
        check_output("rst_y", 32'(bus.bullet_y), 32'd15);
        check_output("rst_active", 32'(bus.bullet_active), 32'd0);
        check_output("rst_shots", 32'(shots_fired), 32'd0);
        check_output("rst_hits", 32'(hits_scored), 32'd0);
        reset = 1'b1;

        // Idle with the game running and no fire.
        for (int i = 0; i < 100; i++) apply_stimulus(1'b1, 1'b0, 5'd7, 1'b0);
        check_output("idle_y", 32'(bus.bullet_y), 32'd15);

        // Launch from column 7, first step one full period later.
        apply_stimulus(1'b1, 1'b1, 5'd7, 1'b0);
        check_output("launch_x", 32'(bus.bullet_x), 32'd7);
        check_output("launch_y", 32'(bus.bullet_y), 32'd14);
        check_output("launch_active", 32'(bus.bullet_active), 32'd1);
        check_output("launch_shots", 32'(shots_fired), 32'd1);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 5'd7, 1'b0);
        check_output("first_step_y", 32'(bus.bullet_y), 32'd13);

        // Full miss: reach row 0, retire one period later.
        for (int i = 0; i < 100 && bus.bullet_y != 4'd0; i++) apply_stimulus(1'b1, 1'b0, 5'd7, 1'b0);
        check_output("reached_top", 32'(bus.bullet_y), 32'd0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 5'd7, 1'b0);
        check_output("top_still_active", 32'(bus.bullet_active), 32'd1);
        apply_stimulus(1'b1, 1'b0, 5'd7, 1'b0);
        check_output("miss_retired", 32'(bus.bullet_active), 32'd0);
        check_output("miss_y", 32'(bus.bullet_y), 32'd15);

        // Fire edges during the 8-cycle cooldown are dropped, the next one launches.
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, (i % 2) == 0, 5'd7, 1'b0);
        check_output("cooldown_drop", 32'(shots_fired), 32'd1);
        apply_stimulus(1'b1, 1'b1, 5'd7, 1'b0);
        check_output("relaunch_active", 32'(bus.bullet_active), 32'd1);
        check_output("relaunch_shots", 32'(shots_fired), 32'd2);

        // Hit arrives at row 9 together with a step tick: hit wins.
        for (int i = 0; i < 100 && bus.bullet_y != 4'd9; i++) apply_stimulus(1'b1, 1'b0, 5'd7, 1'b0);
        check_output("reached_y9", 32'(bus.bullet_y), 32'd9);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 5'd7, 1'b0);
        apply_stimulus(1'b1, 1'b0, 5'd7, 1'b1);
        check_output("hit_retired", 32'(bus.bullet_active), 32'd0);
        check_output("hit_y", 32'(bus.bullet_y), 32'd15);
        check_output("hit_count", 32'(hits_scored), 32'd1);
        apply_stimulus(1'b1, 1'b0, 5'd7, 1'b1);
        check_output("hit_in_cooldown", 32'(hits_scored), 32'd1);
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 5'd7, 1'b0);

        // Held fire with an off-grid column: one launch, clamped to 19.
        apply_stimulus(1'b1, 1'b1, 5'd25, 1'b0);
        check_output("clamp_x", 32'(bus.bullet_x), 32'd19);
        for (int i = 0; i < 199; i++) apply_stimulus(1'b1, 1'b1, 5'd25, 1'b0);
        check_output("held_once", 32'(shots_fired), 32'd3);

        // Fire edge and cannon movement mid-flight have no effect.
        apply_stimulus(1'b1, 1'b0, 5'd3, 1'b0);
        apply_stimulus(1'b1, 1'b1, 5'd3, 1'b0);
        check_output("launch4_shots", 32'(shots_fired), 32'd4);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 5'd10, 1'b0);
        apply_stimulus(1'b1, 1'b1, 5'd10, 1'b0);
        apply_stimulus(1'b1, 1'b0, 5'd10, 1'b0);
        check_output("midflight_drop", 32'(shots_fired), 32'd4);
        check_output("latched_x", 32'(bus.bullet_x), 32'd3);

        // Stop mid-flight retires the bullet without scoring.
        apply_stimulus(1'b0, 1'b0, 5'd10, 1'b0);
        check_output("abort_active", 32'(bus.bullet_active), 32'd0);
        check_output("abort_y", 32'(bus.bullet_y), 32'd15);
        check_output("abort_hits", 32'(hits_scored), 32'd1);

        // Fire edge while stopped does not launch.
        apply_stimulus(1'b0, 1'b1, 5'd10, 1'b0);
        check_output("stopped_no_launch", 32'(shots_fired), 32'd4);
        apply_stimulus(1'b1, 1'b0, 5'd12, 1'b0);

        // Asynchronous reset mid-flight at row 5.
        apply_stimulus(1'b1, 1'b1, 5'd12, 1'b0);
        check_output("launch5_shots", 32'(shots_fired), 32'd5);
        for (int i = 0; i < 100 && bus.bullet_y != 4'd5; i++) apply_stimulus(1'b1, 1'b0, 5'd12, 1'b0);
        check_output("reached_y5", 32'(bus.bullet_y), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_x", 32'(bus.bullet_x), 32'd0);
        check_output("async_y", 32'(bus.bullet_y), 32'd15);
        check_output("async_active", 32'(bus.bullet_active), 32'd0);
        check_output("async_shots", 32'(shots_fired), 32'd0);
        check_output("async_hits", 32'(hits_scored), 32'd0);
        reset = 1'b1;
        model_reset();
        sb.delete();
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 5'd12, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/player_bullet.md
Name: player_bullet

Overview:
- Player-side initiator of the bullet/hit interface consumed by the invaders block.
- On a fire request, launches a single bullet from the cannon column and steps it up the grid one row per step tick.
- Drives bullet_x/bullet_y to the invaders block and retires the bullet on its hit response or at the top of the grid.
- Enforces one bullet in flight plus a post-retire cooldown.

Parameters:
- STEP_DIV, 1250000: clk_25MHz cycles per bullet row step; 20 rows/s at 25 MHz. Must be >= 1.
- COOLDOWN_STEPS, 4: step ticks after retirement before another launch is accepted. 0 means no cooldown.
- LAUNCH_ROW, 14: bullet_y value at launch.

Ports:
- clk_25MHz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  game running; 0 forces IDLE
- fire  in  1  fire button, synchronous and debounced upstream
- player_x  in  5  cannon column, 0..19
- hit  in  1  invaders block reports the bullet struck an invader
- bullet_x  out  5  bullet column
- bullet_y  out  4  bullet row; 0 = top
- bullet_active  out  1  bullet in flight
- shots_fired  out  8  launches since reset, wraps 255->0
- hits_scored  out  8  accepted hits since reset, saturates at 255

Behaviour:
- Reset (reset=0) is asynchronous; all registers clear immediately.
  - state=IDLE, bullet_x=0, bullet_y=15 (off-grid sentinel row, never holds invaders).
  - bullet_active=0, counters 0, step counter 0, fire_q=0.
- fire_q registers fire every cycle. Launch request = fire & ~fire_q (rising edge only). Holding fire launches at most once.
- Step tick: a counter 0..STEP_DIV-1 pulses on terminal count and wraps to 0. It is cleared to 0 on launch and on retire, so the first move comes exactly STEP_DIV cycles after launch.
- State machine (2-bit):
  - IDLE:
    - Launch request with start=1 -> FLYING next cycle.
    - bullet_x = min(player_x, 19).
    - bullet_y = LAUNCH_ROW.
    - bullet_active = 1.
    - shots_fired increments.
  - FLYING:
    - hit=1 -> COOLDOWN next cycle; hits_scored increments (saturating).
    - Else, on tick with bullet_y==0 -> COOLDOWN (miss).
    - Else, on tick -> bullet_y decrements by 1.
    - On either retire: bullet_active=0, bullet_y=15, bullet_x unchanged.
  - COOLDOWN:
    - Counts COOLDOWN_STEPS ticks, then -> IDLE.
    - If COOLDOWN_STEPS=0, goes to IDLE on the next cycle.
- Latency:
  - Edge detected in cycle N -> bullet_active=1 in cycle N+1.
  - hit in cycle N -> bullet_active=0 in cycle N+1.
- Boundary rules:
  - hit and tick in the same cycle: hit wins, no decrement.
  - hit while IDLE or COOLDOWN: ignored, no count.
  - Fire edge during FLYING or COOLDOWN: dropped, not queued.
  - Fire edge and start=0 in the same cycle: no launch.
  - start=0 in any state: -> IDLE next cycle, bullet retired, no hit counted, counters hold.
  - Reset mid-flight: bullet vanishes immediately (asynchronous).
  - player_x changes during flight: no effect; the column is latched at launch.
  - player_x > 19: clamped to 19.
- bullet_y=15 whenever bullet_active=0. This must always hold.

Decomposition:
- Shared package/include (game_defs):
  - GRID_COLS=20, GRID_ROWS=15, OFFGRID_ROW=4'd15.
  - State encodings IDLE/FLYING/COOLDOWN.
  - Coordinate widths 5/4, shared with the invaders block.
- Sub-module step_timer:
  - Parameterised modulo-STEP_DIV counter.
  - Synchronous clear input; one-cycle tick output.
  - Reusable for invader march timing.

Test Plan (STEP_DIV=4, COOLDOWN_STEPS=2 unless stated):
- Reset then release, start=1, no fire -> bullet_y=15, bullet_active=0, counters 0 for 100 cycles.
- Launch: player_x=7, fire rises -> next cycle bullet_x=7, y=14, active=1, shots_fired=1. Then y=13 after 4 cycles, then 12, ...
- Full miss: bullet keeps flying -> y reaches 0, then 4 cycles later active=0 and y=15. A fire edge during the following 8 cycles is ignored; a fire edge after that launches (shots_fired=2).
- Hit: hit pulsed at y=9 in the same cycle as a tick -> next cycle active=0, y=15 (no step to 8), hits_scored=1. A second hit pulse during COOLDOWN leaves hits_scored=1.
- Held fire and clamp: fire held 200 cycles with player_x=25 -> exactly one launch, bullet_x=19. Fire edge mid-flight -> shots_fired unchanged.
- Abort: reset=0 asynchronously at y=5 -> outputs cleared within the same cycle. Separately, start=0 mid-flight -> IDLE next cycle, hits_scored unchanged.
